// File: rtl/is4310_rtu_pkg.sv
// Shared types and constants for the is4310 RTU byte link.
package is4310_rtu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;
  localparam logic LINE_IDLE  = 1'b1;
endpackage

// File: rtl/is4310_uart_rx.sv
// 8N1 receiver: start detect, mid-bit sampling, stop-bit validation.
module is4310_uart_rx
  import is4310_rtu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_i,
  input  logic       rx_enable_i,
  output logic [7:0] byte_o,
  output logic       valid_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  // Detect already costs one cycle, so the start sample lands at mid-bit of the launch edge.
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          armed_q, armed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    armed_d = armed_q;
    valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // armed_q blocks re-triggering on a low line left over from an ignored or bad frame
        if (line_i) armed_d = 1'b1;
        else if (armed_q && rx_enable_i) begin
          state_d = ST_START;
          cnt_d   = '0;
        end else armed_d = 1'b0;
      end
      ST_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (line_i) begin
            state_d = ST_IDLE;
            armed_d = 1'b1;
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {line_i, sh_q[7:1]};
          if (bit_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
          else bit_d = bit_q + 3'd1;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          armed_d = line_i;
          valid_o = line_i;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_o = sh_q;
endmodule

// File: rtl/is4310_rtu_link.sv
// RTU byte link: 8N1 transmitter looped back into the receiver, plus debug byte count.
module is4310_rtu_link
  import is4310_rtu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic [7:0] tx_data,
  input  logic       rx_enable,
  output logic [7:0] rx_data,
  output logic [3:0] debug_counter
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  state_e        tx_q, tx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          line_q, line_d;
  logic [7:0]    rx_data_q, rx_byte;
  logic [3:0]    dbg_q;
  logic          rx_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q   <= ST_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      line_q <= LINE_IDLE;
    end else begin
      tx_q   <= tx_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      line_q <= line_d;
    end
  end

  always_comb begin
    tx_d   = tx_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    line_d = line_q;
    case (tx_q)
      ST_IDLE: begin
        line_d = LINE_IDLE;
        if (tx_enable) begin
          tx_d   = ST_START;
          sh_d   = tx_data;
          cnt_d  = '0;
          line_d = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == LAST) begin
          tx_d   = ST_DATA;
          cnt_d  = '0;
          bit_d  = '0;
          line_d = sh_q[0];
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            tx_d   = ST_STOP;
            line_d = 1'b1;
          end else begin
            bit_d  = bit_q + 3'd1;
            sh_d   = {1'b0, sh_q[7:1]};
            line_d = sh_q[1];
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          // back-to-back launch: start bit follows stop with no idle gap
          if (tx_enable) begin
            tx_d   = ST_START;
            sh_d   = tx_data;
            line_d = 1'b0;
          end else tx_d = ST_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: tx_d = ST_IDLE;
    endcase
  end

  is4310_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .line_i      (line_q),
    .rx_enable_i (rx_enable),
    .byte_o      (rx_byte),
    .valid_o     (rx_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q <= 8'h00;
      dbg_q     <= 4'h0;
    end else if (rx_valid) begin
      rx_data_q <= rx_byte;
      dbg_q     <= dbg_q + 4'h1;
    end
  end

  assign rx_data       = rx_data_q;
  assign debug_counter = dbg_q;
endmodule

// File: tb/tb_is4310_rtu_link.sv
// Scoreboard bench for is4310_rtu_link: stimulus pushes expected updates, monitor checks them.
module tb_is4310_rtu_link;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_enable = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_enable = 1'b0;
  logic [7:0] rx_data;
  logic [3:0] debug_counter;

  typedef struct {
    logic [7:0]  d;
    logic [3:0]  c;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [3:0]  mcnt = 4'h0;
  logic [7:0]  prev_d;
  logic [3:0]  prev_c;
  int unsigned e0;

  is4310_rtu_link #(.CLKS_PER_BIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_enable     (tx_enable),
    .tx_data       (tx_data),
    .rx_enable     (rx_enable),
    .rx_data       (rx_data),
    .debug_counter (debug_counter)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input int unsigned at);
    exp_t e;
    mcnt  = mcnt + 4'h1;
    e.d   = d;
    e.c   = mcnt;
    e.cyc = at;
    q.push_back(e);
  endtask

  // monitor: any output change outside reset must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_d = rx_data;
      prev_c = debug_counter;
    end else if (rx_data !== prev_d || debug_counter !== prev_c) begin
      prev_d = rx_data;
      prev_c = debug_counter;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got %0h/%0h expected no change (cycle %0d)",
                 rx_data, debug_counter, cyc);
      end else begin
        e = q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.d));
        chk("debug_counter", 32'(debug_counter), 32'(e.c));
        chk("update_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk(name, 32'(q.size()), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tx_enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mcnt = 4'h0;
  endtask

  task automatic send1(input logic [7:0] d, input bit expect_rx);
    @(negedge clk);
    tx_data   = d;
    tx_enable = 1'b1;
    e0 = cyc + 1;
    if (expect_rx) push(d, e0 + 38);
    @(negedge clk);
    tx_enable = 1'b0;
  endtask

  initial begin
    // 1: reset state, then idle stability
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_counter", 32'(debug_counter), 32'h0);
    chk("reset_line", 32'(dut.line_q), 32'd1);
    repeat (50) @(negedge clk);
    chk("idle_rx_data", 32'(rx_data), 32'h00);
    chk("idle_counter", 32'(debug_counter), 32'h0);

    // 2: single frame, latency 38
    rx_enable = 1'b1;
    send1(8'hA5, 1'b1);
    drain("drain_single");

    // 3: back-to-back with tx_data changing mid-frame
    @(negedge clk);
    tx_data   = 8'hA5;
    tx_enable = 1'b1;
    e0 = cyc + 1;
    push(8'hA5, e0 + 38);
    push(8'h3C, e0 + 78);
    repeat (6) @(negedge clk);
    tx_data = 8'h3C;
    while (cyc < e0 + 50) @(negedge clk);
    tx_enable = 1'b0;
    drain("drain_b2b");
    chk("b2b_counter", 32'(debug_counter), 32'h3);

    // 4: frame ignored with rx disabled, then accepted
    rx_enable = 1'b0;
    send1(8'h5A, 1'b0);
    repeat (50) @(negedge clk);
    chk("ignored_rx_data", 32'(rx_data), 32'h3C);
    chk("ignored_counter", 32'(debug_counter), 32'h3);
    rx_enable = 1'b1;
    send1(8'h5A, 1'b1);
    drain("drain_enabled");

    // 5: 16 back-to-back frames 0x00..0x0F from a fresh reset, counter wraps
    do_reset();
    chk("rst2_counter", 32'(debug_counter), 32'h0);
    @(negedge clk);
    tx_data   = 8'h00;
    tx_enable = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 16; k++) push(8'(k), e0 + 40 * k + 38);
    for (int k = 1; k < 16; k++) begin
      while (cyc < e0 + 40 * (k - 1) + 1) @(negedge clk);
      tx_data = 8'(k);
    end
    while (cyc < e0 + 40 * 15 + 1) @(negedge clk);
    tx_enable = 1'b0;
    drain("drain_wrap");
    chk("wrap_rx_data", 32'(rx_data), 32'h0F);
    chk("wrap_counter", 32'(debug_counter), 32'h0);

    // 6: reset mid-frame aborts, then a fresh frame is delivered
    send1(8'hC3, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mcnt = 4'h0;
    chk("abort_rx_data", 32'(rx_data), 32'h00);
    chk("abort_counter", 32'(debug_counter), 32'h0);
    chk("abort_line", 32'(dut.line_q), 32'd1);
    repeat (60) @(negedge clk);
    chk("abort_hold_rx_data", 32'(rx_data), 32'h00);
    send1(8'h3C, 1'b1);
    drain("drain_after_abort");
    chk("final_counter", 32'(debug_counter), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
